mux4_rr_sched: RTL
==================

# mux4_rr_sched

Round-robin scheduler that shares the 4:1 single-bit mux datapath among four requesters. Each requester raises `req[i]` and is granted the mux select for a bounded slot. During that slot the scheduler drives `sel`, samples the selected input and presents it registered on `mux_out` with a valid strobe. Sits between the `ui_in` request/data pins and `uo_out` in the TinyTapeout top, replacing a static select input.

## Interface
- `HOLD_W`, 4: width of the slot-length input and internal slot counter.
- `clk`  input  1  system clock, all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ena`  input  1  design enable; low freezes all state and outputs.
- `req`  input  4  per-requester request, level-sensitive.
- `din`  input  4  mux data inputs; `din[i]` belongs to requester i.
- `hold_len`  input  HOLD_W  slot length in cycles; 0 is treated as 1.
- `grant`  output  4  one-hot grant, all-zero when no slot is active.
- `sel`  output  2  mux select, index of the current or last granted requester.
- `mux_out`  output  1  registered `din[sel]`.
- `out_valid`  output  1  high when `mux_out` carries data from a granted cycle.
- `busy`  output  1  high in GRANT state.

## Operation
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If any `req` is high, pick the winner: the first set bit scanning upward from `ptr`, wrapping 3→0.
  - Load `grant` one-hot and set `sel` to the winner.
  - Latch `hold_len` (0→1) into `slot_len` and clear `cnt`.
  - Move to GRANT.
- GRANT:
  - Increment `cnt` each cycle.
  - Leave when `cnt == slot_len-1`, or when `req[sel]` is low (early release); either exit goes to GAP.
  - On exit, clear `grant` and set `ptr = sel+1` (mod 4).
- GAP:
  - Exactly one turnaround cycle with `grant` = 0.
  - Then arbitrate exactly as in IDLE. If no request is pending, go to IDLE.
- `mux_out` datapath:
  - Each enabled cycle: `mux_out <= din[sel]` and `out_valid <= 1` if `grant != 0`.
  - Otherwise `out_valid <= 0` and `mux_out <= 0`.
- `hold_len` changes during a slot have no effect until the next grant.
- `ena` = 0: FSM, `cnt`, `ptr` and all output registers hold their values; requests are not sampled.
- `sel` keeps its value through GAP and IDLE. It changes only on a new grant.

## Timing
- Reset values (asynchronous): state IDLE, `ptr` = 0, `grant` = 0, `sel` = 0, `mux_out` = 0, `out_valid` = 0, `busy` = 0, `cnt` = 0.
- Request to grant: `req` sampled high at edge N in IDLE → `grant` high after edge N. Latency 1 cycle.
- Grant to data: `mux_out`/`out_valid` lag `grant` by 1 cycle.
  - A slot of L cycles yields exactly L consecutive `out_valid` cycles, starting one cycle after `grant` rises.
- Slot length: `grant` is high for `max(hold_len,1)` cycles unless released early.
  - Early release: `req[sel]` low at an edge in GRANT → `grant` low after that edge. The cycle that dropped `req` is not counted as granted.
- Back-to-back service: minimum spacing between two grants is 1 GAP cycle. Grant periods are never adjacent.
- Simultaneous requests: all four held high with `hold_len` = 2 → grants in order 0,1,2,3,0,… with each slot = 2 cycles + 1 GAP.
- Wrap-around: `ptr` after serving requester 3 is 0.
- `cnt` cannot overflow: `slot_len` ≤ 2^HOLD_W−1 and `cnt` saturates its compare.
- Reset asserted mid-slot: all outputs clear immediately (asynchronous). After release, arbitration restarts from `ptr` = 0.

## Structure
- Package `mux4_sched_pkg` holds:
  - state enum `sched_state_t` {IDLE, GRANT, GAP}
  - constants `NUM_REQ` = 4 and `SEL_W` = 2
- Sub-module `rr_pick4`: combinational round-robin picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `found`, `idx[1:0]`.
- The FSM, counter and output registers stay in `mux4_rr_sched`.

## Test plan
- Reset/idle: `rst_n` = 0 then 1, `req` = 0 for 10 cycles → `grant` = 0, `sel` = 0, `mux_out` = 0, `out_valid` = 0 throughout.
- Single requester: `req` = 4'b0100, `hold_len` = 3, `din` = 4'b0100 → `grant` = 4'b0100 for 3 cycles from cycle+1, `sel` = 2, `mux_out` = 1 with `out_valid` for 3 cycles lagging by 1, then 1 GAP, then re-grant to 2.
- Full contention: `req` = 4'hF, `hold_len` = 2 → grant sequence 1,2,4,8,1 (one-hot), each 2 cycles separated by 1 zero cycle.
- Early release: requester 1 granted with `hold_len` = 8, drop `req[1]` after 3 granted cycles → `grant` clears next edge, GAP, next pending requester (e.g. 3 with `req` = 4'b1000) granted.
- `hold_len` = 0 and mid-slot change: `hold_len` = 0 → 1-cycle slots. `hold_len` 2→7 during a slot → current slot still 2 cycles.
- `ena` and reset mid-slot:
  - `ena` = 0 for 4 cycles inside a slot → outputs and `cnt` frozen, and the slot completes its remaining cycles after `ena` = 1.
  - `rst_n` pulsed low mid-slot → immediate clear, and the next grant goes to requester 0 if it is requesting.

Source files
------------

// File: rtl/mux4_sched_pkg.sv
// Shared types and constants for the four-requester round-robin mux scheduler.
package mux4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 3 -> 0.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   idx_o
);

    logic [SEL_W-1:0] cand [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = ptr_i + SEL_W'(gi);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                found_o = 1'b1;
                idx_o   = cand[k];
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing a 4:1 single-bit mux among four requesters,
// with bounded grant slots, a one-cycle turnaround gap and a registered mux output.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ena_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] din_i,
    input  logic [HOLD_W-1:0]  hold_len_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               mux_out_o,
    output logic               out_valid_o,
    output logic               busy_o
);

    sched_state_t       state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [HOLD_W-1:0]  cnt_q;
    logic [HOLD_W-1:0]  slot_len_q;
    logic               mux_out_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [HOLD_W-1:0]  slot_len_d;
    logic               slot_end;

    rr_pick4 u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign slot_len_d = (hold_len_i == '0) ? HOLD_W'(1) : hold_len_i;
    assign slot_end   = (cnt_q >= slot_len_q - HOLD_W'(1)) || !req_i[sel_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            slot_len_q  <= HOLD_W'(1);
            mux_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ena_i) begin
            // Output stage follows the registered grant, so data lags grant by one cycle.
            mux_out_q   <= (grant_q != '0) ? din_i[sel_q] : 1'b0;
            out_valid_q <= (grant_q != '0);

            case (state_q)
                IDLE, GAP: begin
                    if (pick_found) begin
                        state_q    <= GRANT;
                        grant_q    <= idx_to_onehot(pick_idx);
                        sel_q      <= pick_idx;
                        slot_len_q <= slot_len_d;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + HOLD_W'(1);
                    end
                    if (slot_end) begin
                        state_q <= GAP;
                        grant_q <= '0;
                        ptr_q   <= sel_q + SEL_W'(1);
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign sel_o       = sel_q;
    assign mux_out_o   = mux_out_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;

endmodule
